// File: rtl/conv2d_relu.sv
// conv2d_relu: valid stride-1 KxK convolution with bias, rescale,
// saturation and optional ReLU (macro CONV_RELU_EN).
// Ports: clk, reset (sync, high), start/done handshake,
// src/kern/dest base addresses, bias, src_row_size/src_col_size,
// sram_address/sram_readdata/sram_write read port,
// dest_address/dest_writedata/dest_write_en write port.
module conv2d_relu #(
  parameter int K         = 3,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [11:0] src_start_address,
  input  logic [11:0] kern_start_address,
  input  logic [15:0] bias,
  input  logic [5:0]  src_row_size,
  input  logic [5:0]  src_col_size,
  output logic [11:0] sram_address,
  input  logic [15:0] sram_readdata,
  output logic        sram_write,
  input  logic [11:0] dest_start_address,
  output logic [11:0] dest_address,
  output logic [15:0] dest_writedata,
  output logic        dest_write_en
);

  localparam int KK  = K * K;
  localparam int CW  = $clog2(KK + 2);
  localparam int KCW = $clog2(K + 1);

  localparam logic signed [ACC_W-1:0] MAXV = 32767;
  localparam logic signed [ACC_W-1:0] MINV = -32768;

  typedef enum logic [2:0] {
    IDLE, LOAD_K, CONV, WRITE, DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]  cnt;
  logic [KCW-1:0] kc;
  logic [5:0]     orow, ocol;
  logic [5:0]     rows_q, cols_q;
  logic [15:0]    bias_q;
  logic [11:0]    win_base, next_base;

  logic signed [15:0]      w [KK];
  logic signed [ACC_W-1:0] acc;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] sum, shf;
  logic signed [15:0]      sat, res;

  logic last_tap, last_col, last_row;
  logic short_map, accept, shift_w;

  assign last_tap  = cnt == CW'(KK);
  assign last_col  = ocol == cols_q - 6'(K);
  assign last_row  = orow == rows_q - 6'(K);
  assign short_map = (src_row_size < 6'(K))
                   || (src_col_size < 6'(K));
  assign accept    = start
                   && (state == IDLE || state == DONE);
  assign shift_w   = (state == LOAD_K || state == CONV)
                   && cnt != '0;

  // Next window origin: step one column, or jump to
  // the start of the next row after the last column.
  assign next_base = last_col ? win_base + 12'(K)
                              : win_base + 12'd1;

  assign prod = $signed(sram_readdata) * w[0];

  always_comb begin
    sum = acc + {{(ACC_W-16){bias_q[15]}}, bias_q};
    shf = sum >>> FRAC_BITS;
    if (shf > MAXV)      sat = 16'sh7fff;
    else if (shf < MINV) sat = 16'sh8000;
    else                 sat = shf[15:0];
`ifdef CONV_RELU_EN
    res = sat[15] ? 16'sd0 : sat;
`else
    res = sat;
`endif
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start)
                state_n = short_map ? DONE : LOAD_K;
      LOAD_K: if (last_tap) state_n = CONV;
      CONV:   if (last_tap) state_n = WRITE;
      WRITE:  state_n = (last_col && last_row)
                      ? DONE : CONV;
      DONE:   if (start)
                state_n = short_map ? DONE : LOAD_K;
      default: state_n = IDLE;
    endcase
  end

  assign done           = state == DONE;
  assign dest_write_en  = state == WRITE;
  assign dest_writedata = dest_write_en ? res : 16'd0;
  assign sram_write     = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      kc           <= '0;
      orow         <= '0;
      ocol         <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      bias_q       <= '0;
      win_base     <= '0;
      acc          <= '0;
      sram_address <= src_start_address;
      dest_address <= dest_start_address;
      for (int i = 0; i < KK; i++) w[i] <= '0;
    end else begin
      state <= state_n;
      // Weights enter at the tail during LOAD_K and
      // rotate during CONV so w[0] is always the tap
      // matching the sample on sram_readdata.
      if (shift_w) begin
        for (int i = 0; i < KK - 1; i++)
          w[i] <= w[i+1];
        w[KK-1] <= (state == LOAD_K)
                 ? $signed(sram_readdata) : w[0];
      end
      if (accept) begin
        rows_q       <= src_row_size;
        cols_q       <= src_col_size;
        bias_q       <= bias;
        win_base     <= src_start_address;
        dest_address <= dest_start_address;
        cnt          <= '0;
        kc           <= '0;
        orow         <= '0;
        ocol         <= '0;
        if (!short_map)
          sram_address <= kern_start_address;
      end
      unique case (state)
        LOAD_K: begin
          cnt <= last_tap ? '0 : cnt + 1'b1;
          sram_address <= last_tap ? win_base
                                   : sram_address + 12'd1;
        end
        CONV: begin
          cnt <= last_tap ? '0 : cnt + 1'b1;
          if (cnt == '0) acc <= '0;
          else acc <= acc
                    + {{(ACC_W-32){prod[31]}}, prod};
          if (kc == KCW'(K - 1)) begin
            kc <= '0;
            sram_address <= sram_address
                          + 12'(cols_q) - 12'(K - 1);
          end else begin
            kc <= kc + 1'b1;
            sram_address <= sram_address + 12'd1;
          end
        end
        WRITE: begin
          cnt          <= '0;
          kc           <= '0;
          dest_address <= dest_address + 12'd1;
          win_base     <= next_base;
          sram_address <= next_base;
          if (last_col) begin
            ocol <= '0;
            orow <= orow + 6'd1;
          end else begin
            ocol <= ocol + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_relu.sv
// tb_conv2d_relu: directed bench for conv2d_relu (K=3,
// FRAC_BITS=0) with a loop-based reference convolution.
module tb_conv2d_relu;

  localparam int K    = 3;
  localparam int KK   = K * K;
  localparam int FRAC = 0;

  logic        clk = 1'b0;
  logic        reset, start, done;
  logic [11:0] src_a, kern_a, dest_a;
  logic [15:0] bias;
  logic [5:0]  rows, cols;
  logic [11:0] sram_address, dest_address;
  logic [15:0] sram_readdata, dest_writedata;
  logic        sram_write, dest_write_en;

  conv2d_relu #(.K(K), .FRAC_BITS(FRAC), .ACC_W(40)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .src_start_address(src_a),
    .kern_start_address(kern_a),
    .bias(bias),
    .src_row_size(rows), .src_col_size(cols),
    .sram_address(sram_address),
    .sram_readdata(sram_readdata),
    .sram_write(sram_write),
    .dest_start_address(dest_a),
    .dest_address(dest_address),
    .dest_writedata(dest_writedata),
    .dest_write_en(dest_write_en)
  );

  always #5 clk = ~clk;

  logic signed [15:0] mem  [4096];
  logic [15:0]        dmem [4096];

  always @(posedge clk) sram_readdata <= mem[sram_address];
  always @(posedge clk)
    if (dest_write_en) dmem[dest_address] <= dest_writedata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  typedef struct {
    longint a;
    longint d;
  } wr_t;

  wr_t exq[$];
  int  nw = 0, last_wc = 0, start_cyc = 0;
  bit  prev_we = 0;

  function automatic longint model_pix(
      int s, int kb, int b, int c, int orow, int ocol);
    longint acc = 0;
    for (int kr = 0; kr < K; kr++)
      for (int kc = 0; kc < K; kc++)
        acc += longint'(mem[s + (orow+kr)*c + ocol + kc])
             * longint'(mem[kb + kr*K + kc]);
    acc += b;
    acc = acc >>> FRAC;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`ifdef CONV_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  // Single compare point for every write strobe.
  always @(negedge clk) begin
    if (dest_write_en) begin
      wr_t e;
      if (prev_we) chk("back_to_back_we", 1, 0);
      chk("sram_write", sram_write, 0);
      if (exq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exq.pop_front();
        chk("wr_addr", dest_address, e.a);
        chk("wr_data", longint'($signed(dest_writedata)),
            e.d);
        chk("wr_gap", cyc - last_wc,
            nw == 0 ? 2*KK + 2 : KK + 2);
      end
      nw++;
      last_wc = cyc;
    end
    prev_we = dest_write_en;
  end

  task automatic setup(input int s, kb, d, b, r, c);
    int orows, ocols;
    src_a  = 12'(s);
    kern_a = 12'(kb);
    dest_a = 12'(d);
    bias   = 16'(b);
    rows   = 6'(r);
    cols   = 6'(c);
    exq.delete();
    orows = r - K + 1;
    ocols = c - K + 1;
    if (orows > 0 && ocols > 0)
      for (int orow = 0; orow < orows; orow++)
        for (int ocol = 0; ocol < ocols; ocol++)
          exq.push_back('{d + orow*ocols + ocol,
                          model_pix(s, kb, b, c, orow, ocol)});
  endtask

  task automatic go(input string name, input int npix);
    int lim;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    nw    = 0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    last_wc   = cyc;
    lim  = 0;
    seen = 0;
    while (!seen && lim < 2000) begin
      @(negedge clk);
      if (done) seen = 1;
      lim++;
    end
    if (!seen) begin
      chk({name, "_done_timeout"}, 0, 1);
    end else begin
      chk({name, "_done_cycle"}, cyc - start_cyc,
          npix == 0 ? 0
                    : 2*KK + 2 + (npix-1)*(KK+2) + 1);
    end
    chk({name, "_n_writes"}, nw, npix);
    chk({name, "_pending"}, exq.size(), 0);
  endtask

  task automatic chk_lit(string name, int base,
                         input int v0, v1, v2, v3);
    chk({name, "_0"}, longint'($signed(dmem[base+0])), v0);
    chk({name, "_1"}, longint'($signed(dmem[base+1])), v1);
    chk({name, "_2"}, longint'($signed(dmem[base+2])), v2);
    chk({name, "_3"}, longint'($signed(dmem[base+3])), v3);
  endtask

  int lim, nw_hold;
  bit seen;
  logic [11:0] addr_hold;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]  = '0;
      dmem[i] = 16'hdead;
    end
    for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
    for (int i = 0; i < KK; i++) begin
      mem[12'h200 + i] = 16'sd1;
      mem[12'h210 + i] = (i == 4) ? 16'sd1 : 16'sd0;
      mem[12'h220 + i] = -16'sd1;
      mem[12'h230 + i] = 16'sd32767;
      mem[12'h240 + i] = -16'sd32767;
    end
    for (int i = 0; i < 16; i++)
      mem[12'h300 + i] = 16'sd32767;

    start  = 1'b0;
    reset  = 1'b1;
    src_a  = 12'h000;
    kern_a = 12'h200;
    dest_a = 12'h100;
    bias   = '0;
    rows   = 6'd4;
    cols   = 6'd4;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_we", dest_write_en, 0);
    chk("rst_wdata", dest_writedata, 0);
    chk("rst_sram_addr", sram_address, 12'h000);
    chk("rst_dest_addr", dest_address, 12'h100);
    reset = 1'b0;

    chk("model_pin_00", model_pix(0, 'h200, 0, 4, 0, 0), 54);
    chk("model_pin_11", model_pix(0, 'h200, 0, 4, 1, 1), 99);
    chk("model_pin_ctr", model_pix(0, 'h210, -5, 4, 1, 0), 5);

    setup(0, 'h200, 'h100, 0, 4, 4);
    go("sum", 4);
    chk_lit("sum", 'h100, 54, 63, 90, 99);
    repeat (5) @(negedge clk);
    chk("done_held", done, 1);

    setup(0, 'h210, 'h110, -5, 4, 4);
    go("ctr", 4);
    chk_lit("ctr", 'h110, 1, 2, 5, 6);

    setup(0, 'h220, 'h120, 0, 4, 4);
    go("neg", 4);
`ifdef CONV_RELU_EN
    chk_lit("neg", 'h120, 0, 0, 0, 0);
`else
    chk_lit("neg", 'h120, -54, -63, -90, -99);
`endif

    setup('h300, 'h230, 'h130, 0, 4, 4);
    go("satp", 4);
    chk_lit("satp", 'h130, 32767, 32767, 32767, 32767);

    setup('h300, 'h240, 'h138, 0, 4, 4);
    go("satn", 4);
`ifdef CONV_RELU_EN
    chk_lit("satn", 'h138, 0, 0, 0, 0);
`else
    chk_lit("satn", 'h138, -32768, -32768, -32768, -32768);
`endif

    setup(0, 'h200, 'h140, 0, 4, 4);
    @(negedge clk);
    start = 1'b1;
    nw    = 0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    last_wc   = cyc;
    lim  = 0;
    seen = 0;
    while (!seen && lim < 200) begin
      @(negedge clk);
      if (nw == 1) seen = 1;
      lim++;
    end
    chk("mid_first_write_seen", seen, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exq.delete();
    chk("mid_rst_done", done, 0);
    chk("mid_rst_we", dest_write_en, 0);
    chk("mid_rst_wdata", dest_writedata, 0);
    chk("mid_rst_sram_addr", sram_address, 12'h000);
    chk("mid_rst_dest_addr", dest_address, 12'h140);
    nw_hold = nw;
    repeat (40) @(negedge clk);
    chk("mid_no_more_writes", nw, nw_hold);
    chk("mid_idle_done", done, 0);
    chk("mid_partial", dmem['h141], 16'hdead);

    setup(0, 'h200, 'h150, 0, 4, 4);
    go("rerun", 4);
    chk_lit("rerun", 'h150, 54, 63, 90, 99);

    addr_hold = sram_address;
    setup(0, 'h200, 'h160, 0, 2, 5);
    go("short", 0);
    chk("short_no_reads", sram_address, addr_hold);
    chk("short_untouched", dmem['h160], 16'hdead);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2d_relu.md
Name: conv2d_relu

Overview:
- Convolution stage directly upstream of the max-pooling stage in the MNIST pipeline.
- Reads a 2-D signed 16-bit feature map and a KxK kernel from SRAM, and computes a valid, stride-1 convolution.
- Adds a bias, applies fixed-point rescale, saturation and ReLU.
- Writes the output map row-major to the destination SRAM region that max pooling consumes.

Parameters:
- K, 3, kernel side length (1..5).
- FRAC_BITS, 8, arithmetic right shift applied to the accumulator before saturation.
- ACC_W, 40, internal accumulator width; must be at least 32 + clog2(K*K).

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse begins a run when idle or done
- done  output  1  high after last write; held until next accepted start or reset
- src_start_address  input  12  base of input map, row-major
- kern_start_address  input  12  base of K*K weights, row-major
- bias  input  16  signed bias added before shift, aligned to accumulator LSB
- src_row_size  input  6  input rows
- src_col_size  input  6  input columns
- sram_address  output  12  read address
- sram_readdata  input  16  signed; valid one cycle after address is presented
- sram_write  output  1  tied 0
- dest_start_address  input  12  base of output map
- dest_address  output  12  write address
- dest_writedata  output  16  signed result
- dest_write_en  output  1  one-cycle write strobe

Behaviour:
- Reset values: done=0, dest_write_en=0, dest_writedata=0, sram_address=src_start_address, dest_address=dest_start_address, state=IDLE, all counters and accumulator 0.
- Input addressing: input element (r,c) is at src_start_address + r*src_col_size + c.
- Output map: (src_row_size-K+1) x (src_col_size-K+1). Element (orow,ocol) is written at dest_start_address + orow*out_cols + ocol.
- IDLE: on start, go to LOAD_K; start is ignored in every other state except DONE.
- LOAD_K:
  - Issue kern_start_address+0 .. K*K-1 on consecutive cycles.
  - Capture each returned word one cycle later into internal weight register i.
  - Takes K*K+1 cycles, then CONV for output (0,0).
  - If src_row_size<K or src_col_size<K, go directly to DONE from IDLE with no reads or writes.
- CONV:
  - Issue K*K input addresses for the current window in kernel order (kr, kc).
  - Accumulator is cleared at the first issue.
  - Each returned sample is multiplied by its weight (signed 16x16 -> 32) and summed into the ACC_W-bit accumulator.
  - Takes K*K+1 cycles, then WRITE.
- WRITE (one cycle):
  - result = (acc + sign-extended bias) >>> FRAC_BITS.
  - Saturate to [-32768, 32767], then ReLU if enabled.
  - Drive dest_writedata and dest_write_en=1, with dest_address pointing at the current output.
  - Advance ocol; wrap to 0 and increment orow at out_cols.
  - After the last output go to DONE, else CONV.
- Throughput and latency: K*K+2 cycles per output pixel; dest_write_en is high exactly once per pixel and never two cycles in a row.
- DONE:
  - done=1 and dest_write_en=0.
  - start clears done on the next cycle and returns to LOAD_K, re-sampling all address and size inputs.
- Input sampling: address and size inputs are sampled at accepted start only.
- Reset mid-run: abandon within the same edge and return to reset values; no further writes.
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: negative saturated results are written as 0.
- Undefined: the signed saturated result is written unchanged, so the block acts as a pure convolution.

Test Plan:
- 4x4 map of values 1..16, K=3, all weights 1, FRAC_BITS=0, bias 0, dest 0x100 -> writes 54, 63, 90, 99 at 0x100..0x103, one per 11 cycles; done rises after the fourth write.
- Same map, centre weight 1, others 0, bias -5 -> 1, 2, 5, 6.
- All weights -1 -> all outputs 0 with CONV_RELU_EN; -54, -63, -90, -99 without it.
- Map all 32767, weights all 32767, FRAC_BITS=0 -> every output 32767 (saturation); weights -32767 without CONV_RELU_EN -> -32768.
- Pulse reset during the second CONV -> no further dest_write_en, done=0, state IDLE; a new start then completes the full run correctly.
- 2x5 map with K=3 -> done asserted within 2 cycles of start, zero writes, no SRAM reads issued.
